uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART RX/TX byte FIFOs and a simple 16-bit register bus. It pops command bytes from the RX FIFO and decodes single-register read and write commands. It runs one bus cycle per command and pushes response bytes into the TX FIFO. It is the only reader of the RX FIFO and the only writer of the TX FIFO.

Parameters:
TIMEOUT, 255, bus cycles to wait for i_bus_ack before aborting; range 1..255.
CMD_WR, 8'h57, write opcode ('W').
CMD_RD, 8'h52, read opcode ('R').

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset_n  input  1  asynchronous active-low reset
i_rx_dat  input  8  RX FIFO head byte, valid while i_rx_empty=0
i_rx_empty  input  1  RX FIFO empty
o_rx_pop  output  1  pop RX head this cycle
o_tx_dat  output  8  byte to TX FIFO
o_tx_push  output  1  push o_tx_dat this cycle
i_tx_full  input  1  TX FIFO full
o_bus_cs  output  1  bus cycle active
o_bus_we  output  1  1=write, 0=read; valid with o_bus_cs
o_bus_addr  output  16  register address
o_bus_wdat  output  16  write data
i_bus_rdat  input  16  read data, sampled on ack
i_bus_ack  input  1  bus cycle complete, single-cycle pulse
o_busy  output  1  high in any state except S_CMD

Behaviour:
- Reset (async, i_reset_n=0): state=S_CMD; o_bus_cs=0, o_bus_we=0, o_bus_addr=0, o_bus_wdat=0, o_tx_dat=0, timeout counter=0, read-data register=0. o_rx_pop=0, o_tx_push=0 and o_busy=0 while reset is low.
- Protocol, big-endian:
  - Write: W, AH, AL, DH, DL. Response: 'K' (8'h4B).
  - Read: R, AH, AL. Response: DH, DL.
  - Bus timeout on either command: single byte 'T' (8'h54), replacing the normal response.
  - Any other opcode: 'E' (8'h45). No further bytes are consumed.
- RX handshake: in byte-fetch states S_CMD, S_AH, S_AL, S_DH, S_DL:
  - o_rx_pop = ~i_rx_empty (combinational).
  - i_rx_dat is captured on the same edge as the pop and the state advances.
  - If empty, the state holds; there is no inter-byte timeout.
  - Back-to-back pops on consecutive cycles are legal.
- TX handshake: in S_RSP1/S_RSP2:
  - o_tx_dat is registered and loaded on entry to the state.
  - o_tx_push = ~i_tx_full (combinational).
  - The state advances on the push edge. While full, the state holds with o_tx_dat stable.
- State transitions:
  - S_CMD: byte==CMD_WR -> S_AH with we=1; byte==CMD_RD -> S_AH with we=0; other -> S_RSP2 with 'E'.
  - S_AH -> S_AL, loading addr[15:8]. S_AL loads addr[7:0], then goes to S_DH if we=1, else S_BUS.
  - S_DH -> S_DL, loading wdat[15:8]. S_DL loads wdat[7:0], then goes to S_BUS.
  - S_BUS: o_bus_cs=1 registered from the entry edge; addr/we/wdat are stable for the whole cycle. The counter increments each cycle.
    - i_bus_ack=1: cs drops on the next edge and the counter clears. Write -> S_RSP2 with 'K'. Read -> latch i_bus_rdat, then S_RSP1 with rdat[15:8].
    - Counter reaches TIMEOUT with no ack: cs drops, counter clears, go to S_RSP2 with 'T'. If ack and timeout occur in the same cycle, ack wins.
  - S_RSP1 -> S_RSP2 (rdat[7:0]) on push. S_RSP2 -> S_CMD on push.
- Minimum latency, FIFOs never empty/full, ack on the first S_BUS cycle:
  - Write: 5 pop cycles + 1 bus cycle + 1 push cycle.
  - Read: 3 + 1 + 2.
- o_bus_cs is never high outside S_BUS. i_bus_ack outside S_BUS is ignored.
- Reset mid-command or mid-bus-cycle: abort immediately and drop cs. Partial command bytes are discarded; FIFO contents are not touched.
- Push and pop are never asserted in the same cycle.

Test Plan:
- Write: RX holds 57 12 34 AB CD, ack on the 3rd S_BUS cycle -> one bus write with addr=16'h1234, wdat=16'hABCD, we=1, cs high exactly 3 cycles; TX receives 4B.
- Read: RX holds 52 00 10, i_bus_rdat=16'hBEEF with ack after 1 cycle -> read addr=16'h0010, we=0; TX receives BE then EF; o_busy returns to 0.
- Timeout: TIMEOUT=4, read command, ack never asserted -> cs high exactly 4 cycles; TX receives 54; the next command is processed normally.
- Bad opcode plus flow control: RX holds 41 52 00 01; i_tx_full held high for 10 cycles during each response; rdat=16'h0102 -> TX receives 45, then 01 02. o_tx_dat is stable while full, and no pop occurs during response states.
- Starved RX: write bytes arrive one every 7 cycles -> no pop while empty; bus write occurs only after DL; result matches the write test.
- Async reset: assert i_reset_n=0 mid S_BUS -> cs=0 within the same cycle without a clock edge; after release, a fresh 52 00 10 completes correctly.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: decodes 'W'/'R' register commands from the RX byte FIFO,
// runs one 16-bit bus cycle per command and pushes the response into the TX byte FIFO.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_empty,
    output logic        o_rx_pop,
    output logic [7:0]  o_tx_dat,
    output logic        o_tx_push,
    input  logic        i_tx_full,
    output logic        o_bus_cs,
    output logic        o_bus_we,
    output logic [15:0] o_bus_addr,
    output logic [15:0] o_bus_wdat,
    input  logic [15:0] i_bus_rdat,
    input  logic        i_bus_ack,
    output logic        o_busy
);

    localparam logic [7:0] RSP_K   = 8'h4B;
    localparam logic [7:0] RSP_T   = 8'h54;
    localparam logic [7:0] RSP_E   = 8'h45;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CMD, S_AH, S_AL, S_DH, S_DL, S_BUS, S_RSP1, S_RSP2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        cs_q, cs_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tx_dat_q, tx_dat_d;
    logic        rx_pop;
    logic        tx_push;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_CMD;
            we_q     <= 1'b0;
            cs_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdat_q   <= 16'h0000;
            rdat_q   <= 16'h0000;
            cnt_q    <= 8'h00;
            tx_dat_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            cs_q     <= cs_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            cnt_q    <= cnt_d;
            tx_dat_q <= tx_dat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        cs_d     = cs_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        cnt_d    = cnt_q;
        tx_dat_d = tx_dat_q;
        rx_pop   = 1'b0;
        tx_push  = 1'b0;

        case (state_q)
            S_CMD: begin
                rx_pop = ~i_rx_empty;
                if (!i_rx_empty) begin
                    if (i_rx_dat == CMD_WR) begin
                        we_d    = 1'b1;
                        state_d = S_AH;
                    end else if (i_rx_dat == CMD_RD) begin
                        we_d    = 1'b0;
                        state_d = S_AH;
                    end else begin
                        tx_dat_d = RSP_E;
                        state_d  = S_RSP2;
                    end
                end
            end
            S_AH: begin
                rx_pop = ~i_rx_empty;
                if (!i_rx_empty) begin
                    addr_d[15:8] = i_rx_dat;
                    state_d      = S_AL;
                end
            end
            S_AL: begin
                rx_pop = ~i_rx_empty;
                if (!i_rx_empty) begin
                    addr_d[7:0] = i_rx_dat;
                    if (we_q) begin
                        state_d = S_DH;
                    end else begin
                        cs_d    = 1'b1;
                        cnt_d   = 8'h00;
                        state_d = S_BUS;
                    end
                end
            end
            S_DH: begin
                rx_pop = ~i_rx_empty;
                if (!i_rx_empty) begin
                    wdat_d[15:8] = i_rx_dat;
                    state_d      = S_DL;
                end
            end
            S_DL: begin
                rx_pop = ~i_rx_empty;
                if (!i_rx_empty) begin
                    wdat_d[7:0] = i_rx_dat;
                    cs_d        = 1'b1;
                    cnt_d       = 8'h00;
                    state_d     = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is checked first so a late ack on the final cycle still completes the command.
                if (i_bus_ack) begin
                    cs_d  = 1'b0;
                    cnt_d = 8'h00;
                    if (we_q) begin
                        tx_dat_d = RSP_K;
                        state_d  = S_RSP2;
                    end else begin
                        rdat_d   = i_bus_rdat;
                        tx_dat_d = i_bus_rdat[15:8];
                        state_d  = S_RSP1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cs_d     = 1'b0;
                    cnt_d    = 8'h00;
                    tx_dat_d = RSP_T;
                    state_d  = S_RSP2;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            S_RSP1: begin
                tx_push = ~i_tx_full;
                if (!i_tx_full) begin
                    tx_dat_d = rdat_q[7:0];
                    state_d  = S_RSP2;
                end
            end
            S_RSP2: begin
                tx_push = ~i_tx_full;
                if (!i_tx_full) begin
                    state_d = S_CMD;
                end
            end
            default: begin
                cs_d    = 1'b0;
                state_d = S_CMD;
            end
        endcase
    end

    // The pop qualifier is gated by reset so the RX FIFO is never drained while reset is held.
    assign o_rx_pop   = rx_pop & i_reset_n;
    assign o_tx_push  = tx_push;
    assign o_tx_dat   = tx_dat_q;
    assign o_bus_cs   = cs_q;
    assign o_bus_we   = we_q;
    assign o_bus_addr = addr_q;
    assign o_bus_wdat = wdat_q;
    assign o_busy     = (state_q != S_CMD);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with FIFO models and a bus responder.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [7:0]  i_rx_dat;
    logic        i_rx_empty;
    logic        o_rx_pop;
    logic [7:0]  o_tx_dat;
    logic        o_tx_push;
    logic        i_tx_full;
    logic        o_bus_cs;
    logic        o_bus_we;
    logic [15:0] o_bus_addr;
    logic [15:0] o_bus_wdat;
    logic [15:0] i_bus_rdat;
    logic        i_bus_ack;
    logic        o_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] rx_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] tx_log [0:63];
    int         tx_cnt = 0;
    int         pop_cnt = 0;
    int         busy_cnt = 0;
    int         overlap_cnt = 0;
    int         pop_empty_cnt = 0;

    int          ack_at = 0;
    int          cs_cyc = 0;
    int          bus_cnt = 0;
    int          last_cs_len = 0;
    int          bus_unstable = 0;
    logic [15:0] bus_addr = 16'h0;
    logic [15:0] bus_wdat = 16'h0;
    logic        bus_we = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_rx_dat   (i_rx_dat),
        .i_rx_empty (i_rx_empty),
        .o_rx_pop   (o_rx_pop),
        .o_tx_dat   (o_tx_dat),
        .o_tx_push  (o_tx_push),
        .i_tx_full  (i_tx_full),
        .o_bus_cs   (o_bus_cs),
        .o_bus_we   (o_bus_we),
        .o_bus_addr (o_bus_addr),
        .o_bus_wdat (o_bus_wdat),
        .i_bus_rdat (i_bus_rdat),
        .i_bus_ack  (i_bus_ack),
        .o_busy     (o_busy)
    );

    assign i_rx_empty = (rd_ptr == wr_ptr);
    assign i_rx_dat   = rx_mem[rd_ptr[5:0]];

    // FIFO side: acts on the handshakes the DUT presents for this edge.
    always @(posedge clk) begin
        if (o_rx_pop && !i_rx_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
        if (o_rx_pop && i_rx_empty) pop_empty_cnt <= pop_empty_cnt + 1;
        if (o_tx_push && !i_tx_full) begin
            tx_log[tx_cnt[5:0]] <= o_tx_dat;
            tx_cnt              <= tx_cnt + 1;
        end
        if (o_rx_pop && o_tx_push) overlap_cnt <= overlap_cnt + 1;
        if (o_busy) busy_cnt <= busy_cnt + 1;
    end

    // Bus slave: acks on the ack_at-th cycle of cs (0 = never), logs the transaction.
    always @(negedge clk) begin
        if (o_bus_cs) begin
            if (cs_cyc == 0) begin
                bus_cnt  <= bus_cnt + 1;
                bus_addr <= o_bus_addr;
                bus_we   <= o_bus_we;
                bus_wdat <= o_bus_wdat;
            end else if (o_bus_addr !== bus_addr || o_bus_we !== bus_we || o_bus_wdat !== bus_wdat) begin
                bus_unstable <= bus_unstable + 1;
            end
            cs_cyc    <= cs_cyc + 1;
            i_bus_ack <= (ack_at != 0) && (cs_cyc + 1 == ack_at);
        end else begin
            if (cs_cyc != 0) last_cs_len <= cs_cyc;
            cs_cyc    <= 0;
            i_bus_ack <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(negedge clk);
        rx_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (tx_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, tx_cnt, target);
    endtask

    initial begin
        int t0, b0, p0, busy0, k;
        logic [7:0] wr_bytes [0:4];
        wr_bytes[0] = 8'h57; wr_bytes[1] = 8'h12; wr_bytes[2] = 8'h34;
        wr_bytes[3] = 8'hAB; wr_bytes[4] = 8'hCD;

        i_reset_n  = 1'b0;
        i_tx_full  = 1'b0;
        i_bus_rdat = 16'h0000;
        ack_at     = 3;

        // Reset state, with a write command already waiting in the RX FIFO.
        for (int i = 0; i < 5; i++) push_rx(wr_bytes[i]);
        cycles(2);
        chk("rst_pop", o_rx_pop, 0);
        chk("rst_push", o_tx_push, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_cs", o_bus_cs, 0);
        chk("rst_we", o_bus_we, 0);
        chk("rst_addr", o_bus_addr, 16'h0000);
        chk("rst_wdat", o_bus_wdat, 16'h0000);
        chk("rst_txdat", o_tx_dat, 8'h00);

        // Write, ack on 3rd bus cycle.
        t0 = tx_cnt; b0 = bus_cnt; busy0 = busy_cnt;
        i_reset_n = 1'b1;
        wait_tx("wr_tx_cnt", t0 + 1, 60);
        cycles(2);
        chk("wr_rsp", tx_log[t0[5:0]], 8'h4B);
        chk("wr_bus_cnt", bus_cnt - b0, 1);
        chk("wr_addr", bus_addr, 16'h1234);
        chk("wr_wdat", bus_wdat, 16'hABCD);
        chk("wr_we", bus_we, 1);
        chk("wr_cs_len", last_cs_len, 3);
        chk("wr_busy_cycles", busy_cnt - busy0, 8);
        chk("wr_idle", o_busy, 0);

        // Read, ack on first bus cycle.
        ack_at = 1; i_bus_rdat = 16'hBEEF;
        t0 = tx_cnt; busy0 = busy_cnt;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h10);
        wait_tx("rd_tx_cnt", t0 + 2, 60);
        cycles(2);
        chk("rd_rsp_hi", tx_log[t0[5:0]], 8'hBE);
        chk("rd_rsp_lo", tx_log[6'(t0 + 1)], 8'hEF);
        chk("rd_addr", bus_addr, 16'h0010);
        chk("rd_we", bus_we, 0);
        chk("rd_cs_len", last_cs_len, 1);
        chk("rd_busy_cycles", busy_cnt - busy0, 5);
        chk("rd_idle", o_busy, 0);

        // Timeout, then a normal read.
        ack_at = 0;
        t0 = tx_cnt;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h20);
        wait_tx("to_tx_cnt", t0 + 1, 60);
        cycles(2);
        chk("to_rsp", tx_log[t0[5:0]], 8'h54);
        chk("to_cs_len", last_cs_len, 4);
        chk("to_addr", bus_addr, 16'h0020);
        ack_at = 1; i_bus_rdat = 16'h1357;
        t0 = tx_cnt;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h30);
        wait_tx("to_next_tx_cnt", t0 + 2, 60);
        cycles(2);
        chk("to_next_hi", tx_log[t0[5:0]], 8'h13);
        chk("to_next_lo", tx_log[6'(t0 + 1)], 8'h57);
        chk("to_next_addr", bus_addr, 16'h0030);

        // Bad opcode plus TX back-pressure.
        i_tx_full = 1'b1; i_bus_rdat = 16'h0102;
        t0 = tx_cnt; p0 = pop_cnt;
        push_rx(8'h41); push_rx(8'h52); push_rx(8'h00); push_rx(8'h01);
        cycles(10);
        chk("bad_pop_hold", pop_cnt - p0, 1);
        chk("bad_txdat_hold", o_tx_dat, 8'h45);
        chk("bad_no_push", tx_cnt - t0, 0);
        i_tx_full = 1'b0;
        k = 0;
        while (tx_cnt == t0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        i_tx_full = 1'b1;
        chk("bad_e_pushed", tx_cnt - t0, 1);
        cycles(14);
        chk("fc_txdat_hold1", o_tx_dat, 8'h01);
        chk("fc_pops", pop_cnt - p0, 4);
        chk("fc_no_push", tx_cnt - t0, 1);
        cycles(3);
        chk("fc_txdat_hold2", o_tx_dat, 8'h01);
        i_tx_full = 1'b0;
        wait_tx("fc_tx_cnt", t0 + 3, 40);
        cycles(2);
        chk("fc_rsp0", tx_log[t0[5:0]], 8'h45);
        chk("fc_rsp1", tx_log[6'(t0 + 1)], 8'h01);
        chk("fc_rsp2", tx_log[6'(t0 + 2)], 8'h02);

        // Starved RX: write bytes arrive every 7 cycles.
        ack_at = 3;
        t0 = tx_cnt; b0 = bus_cnt;
        for (int i = 0; i < 4; i++) begin
            cycles(6);
            push_rx(wr_bytes[i]);
        end
        cycles(6);
        chk("st_no_bus_before_dl", bus_cnt - b0, 0);
        chk("st_busy_waiting", o_busy, 1);
        push_rx(wr_bytes[4]);
        wait_tx("st_tx_cnt", t0 + 1, 60);
        cycles(2);
        chk("st_rsp", tx_log[t0[5:0]], 8'h4B);
        chk("st_addr", bus_addr, 16'h1234);
        chk("st_wdat", bus_wdat, 16'hABCD);
        chk("st_we", bus_we, 1);
        chk("st_cs_len", last_cs_len, 3);

        // Async reset in the middle of a bus cycle.
        ack_at = 0;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h10);
        k = 0;
        while (!o_bus_cs && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("ar_cs_seen", o_bus_cs, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("ar_cs_dropped", o_bus_cs, 0);
        chk("ar_busy", o_busy, 0);
        chk("ar_addr", o_bus_addr, 16'h0000);
        cycles(2);
        i_reset_n = 1'b1;
        ack_at = 1; i_bus_rdat = 16'hBEEF;
        t0 = tx_cnt;
        push_rx(8'h52); push_rx(8'h00); push_rx(8'h10);
        wait_tx("ar_tx_cnt", t0 + 2, 60);
        cycles(2);
        chk("ar_rsp_hi", tx_log[t0[5:0]], 8'hBE);
        chk("ar_rsp_lo", tx_log[6'(t0 + 1)], 8'hEF);
        chk("ar_addr_after", bus_addr, 16'h0010);
        chk("ar_idle", o_busy, 0);

        // Global handshake properties over the whole run.
        chk("pop_push_overlap", overlap_cnt, 0);
        chk("pop_while_empty", pop_empty_cnt, 0);
        chk("bus_fields_stable", bus_unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
